// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback from the IR opcode and
// produces every datapath enable and mux select as a Moore decode of state.
// Memory states stall on mem_ready, with an optional watchdog that aborts
// back to FETCH after TIMEOUT consecutive stall cycles.
module multicycle_main_control #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Counter value at which one more stall cycle trips the watchdog.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic             WDOG_EN  = (TIMEOUT != 32'sd0);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             illegal_op_r;
  logic             mem_timeout_r;
  logic             illegal_s;
  logic             timeout_s;
  logic             wait_s;
  logic             stall_limit_s;

  assign wait_s        = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
  assign stall_limit_s = WDOG_EN && (cnt_r == CNT_LAST) && !mem_ready;

  // Next-state selection, including the decode dispatch and watchdog abort.
  always_comb begin
    state_nxt_s = state_r;
    illegal_s   = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          state_nxt_s = S_DECODE;
        end else if (stall_limit_s) begin
          state_nxt_s = S_FETCH;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE: state_nxt_s = S_EXEC;
          OP_LW:    state_nxt_s = S_MEMADR;
          OP_SW:    state_nxt_s = S_MEMADR;
          OP_BEQ:   state_nxt_s = S_BRANCH;
          OP_J:     state_nxt_s = S_JUMP;
          OP_ADDI:  state_nxt_s = S_ADDI_EX;
          default: begin
            state_nxt_s = S_FETCH;
            illegal_s   = 1'b1;
          end
        endcase
      end
      // IR is not written after FETCH, so Opcode is still valid here.
      S_MEMADR: begin
        if (Opcode == OP_LW) begin
          state_nxt_s = S_MEMRD;
        end else begin
          state_nxt_s = S_MEMWR;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_nxt_s = S_MEMWB;
        end else if (stall_limit_s) begin
          state_nxt_s = S_FETCH;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_nxt_s = S_FETCH;
        end else if (stall_limit_s) begin
          state_nxt_s = S_FETCH;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = S_MEMWR;
        end
      end
      S_EXEC:    state_nxt_s = S_RWB;
      S_ADDI_EX: state_nxt_s = S_ADDI_WB;
      S_MEMWB:   state_nxt_s = S_FETCH;
      S_RWB:     state_nxt_s = S_FETCH;
      S_BRANCH:  state_nxt_s = S_FETCH;
      S_JUMP:    state_nxt_s = S_FETCH;
      S_ADDI_WB: state_nxt_s = S_FETCH;
      default:   state_nxt_s = S_FETCH;
    endcase
  end

  // Stall counter: clears on any state change, ready or abort; saturates.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if ((state_nxt_s != state_r) || mem_ready || timeout_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (wait_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State, stall counter and one-cycle pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_FETCH;
      cnt_r         <= {CNT_W{1'b0}};
      illegal_op_r  <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      illegal_op_r  <= illegal_s;
      mem_timeout_r <= timeout_s;
    end
  end

  assign state = state_r;

  // Moore output decode; everything is held at 0 while reset is asserted.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (!rst_n) begin
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
    end else begin
      illegal_op  = illegal_op_r;
      mem_timeout = mem_timeout_r;
      case (state_r)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          // PC/IR only load once the instruction word actually arrives.
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR, S_ADDI_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDI_WB: RegWrite = 1'b1;
        default: begin
          PCWrite = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed testbench for multicycle_main_control (watchdog TIMEOUT=4).
module tb_multicycle_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;
  logic [15:0] ctrl;

  int checks = 0;
  int errors = 0;

  multicycle_main_control #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout)
  );

  // Control word: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  // PCSource[1:0],ALUOp[1:0],ALUSrcA,ALUSrcB[1:0],RegWrite,RegDst
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                 PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; Opcode = 6'b000000;
    #1;
    checks++;
    if (ctrl !== 16'h0000 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_pre_edge: ctrl=%h want 0000", ctrl);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (state !== 4'd0 || ctrl !== 16'h0000 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
        errors++; $display("FAIL reset_cycle%0d: state=%0d ctrl=%h want 0/0000", i, state, ctrl);
      end
    end
    rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || ctrl !== 16'h9204) begin
      errors++; $display("FAIL reset_release: state=%0d ctrl=%h want 0/9204", state, ctrl);
    end
  endtask

  task automatic test_paths();
    logic [5:0]  ops  [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    int          lens [6] = '{4, 5, 4, 3, 3, 4};
    logic [3:0]  st   [6][5] = '{'{4'd0, 4'd1, 4'd6,  4'd7,  4'd0},
                                 '{4'd0, 4'd1, 4'd2,  4'd3,  4'd4},
                                 '{4'd0, 4'd1, 4'd2,  4'd5,  4'd0},
                                 '{4'd0, 4'd1, 4'd8,  4'd0,  4'd0},
                                 '{4'd0, 4'd1, 4'd9,  4'd0,  4'd0},
                                 '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0}};
    logic [15:0] cw   [6][5] = '{'{16'h9204, 16'h000C, 16'h0050, 16'h0003, 16'h0000},
                                 '{16'h9204, 16'h000C, 16'h0018, 16'h3000, 16'h0402},
                                 '{16'h9204, 16'h000C, 16'h0018, 16'h2800, 16'h0000},
                                 '{16'h9204, 16'h000C, 16'h40B0, 16'h0000, 16'h0000},
                                 '{16'h9204, 16'h000C, 16'h8100, 16'h0000, 16'h0000},
                                 '{16'h9204, 16'h000C, 16'h0018, 16'h0002, 16'h0000}};
    mem_ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      Opcode = ops[p];
      for (int k = 0; k < lens[p]; k++) begin
        #1;
        checks++;
        if (state !== st[p][k] || ctrl !== cw[p][k] || illegal_op !== 1'b0) begin
          errors++;
          $display("FAIL path op=%b step%0d: state=%0d ctrl=%h ill=%b want %0d/%h/0",
                   ops[p], k, state, ctrl, illegal_op, st[p][k], cw[p][k]);
        end
        tick();
      end
      checks++;
      if (state !== 4'd0) begin
        errors++; $display("FAIL path op=%b latency: state=%0d want 0", ops[p], state);
      end
    end
  endtask

  task automatic test_fetch_stall();
    Opcode = 6'b100011; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state !== 4'd0 || ctrl !== 16'h1004 || mem_timeout !== 1'b0) begin
        errors++; $display("FAIL fetch_stall%0d: state=%0d ctrl=%h want 0/1004", i, state, ctrl);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || ctrl !== 16'h9204) begin
      errors++; $display("FAIL fetch_ready: state=%0d ctrl=%h want 0/9204", state, ctrl);
    end
    tick();
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (state !== 4'(i) || mem_timeout !== 1'b0) begin
        errors++; $display("FAIL lw_stall_path: state=%0d want %0d", state, i);
      end
      if (i == 4) begin
        checks++;
        if (MemtoReg !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b0) begin
          errors++; $display("FAIL lw_memwb: ctrl=%h want 0402", ctrl);
        end
      end
      tick();
    end
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL lw_stall_end: state=%0d want 0", state);
    end
  endtask

  task automatic test_illegal();
    Opcode = 6'b111111; mem_ready = 1'b1;
    tick();
    checks++;
    if (state !== 4'd1 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_decode: state=%0d ill=%b want 1/0", state, illegal_op);
    end
    mem_ready = 1'b0;
    tick();
    checks++;
    if (state !== 4'd0 || illegal_op !== 1'b1 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse: state=%0d ill=%b ctrl=%h want 0/1", state, illegal_op, ctrl);
    end
    tick();
    checks++;
    if (state !== 4'd0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL illegal_once: state=%0d ill=%b want 0/0", state, illegal_op);
    end
  endtask

  task automatic test_watchdog();
    Opcode = 6'b100011; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state !== 4'd3 || mem_timeout !== 1'b0) begin
        errors++; $display("FAIL wdog_stall%0d: state=%0d tmo=%b want 3/0", i, state, mem_timeout);
      end
      tick();
    end
    checks++;
    if (state !== 4'd0 || mem_timeout !== 1'b1 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      errors++; $display("FAIL wdog_abort: state=%0d tmo=%b ctrl=%h want 0/1", state, mem_timeout, ctrl);
    end
    tick();
    checks++;
    if (state !== 4'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL wdog_once: state=%0d tmo=%b want 0/0", state, mem_timeout);
    end
    mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state !== 4'd3) begin
        errors++; $display("FAIL wdog2_stall%0d: state=%0d want 3", i, state);
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (state !== 4'd4 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL wdog_ready_wins: state=%0d tmo=%b want 4/0", state, mem_timeout);
    end
    tick();
    checks++;
    if (state !== 4'd0 || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL wdog_ready_after: state=%0d tmo=%b want 0/0", state, mem_timeout);
    end
  endtask

  task automatic test_midop_reset();
    Opcode = 6'b101011; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      errors++; $display("FAIL midrst_memwr: state=%0d memwrite=%b want 5/1", state, MemWrite);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd5 || ctrl !== 16'h0000) begin
      errors++; $display("FAIL midrst_comb: state=%0d ctrl=%h want 5/0000", state, ctrl);
    end
    tick();
    checks++;
    if (state !== 4'd0 || ctrl !== 16'h0000) begin
      errors++; $display("FAIL midrst_edge: state=%0d ctrl=%h want 0/0000", state, ctrl);
    end
    rst_n = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || ctrl !== 16'h9204) begin
      errors++; $display("FAIL midrst_release: state=%0d ctrl=%h want 0/9204", state, ctrl);
    end
  endtask

  initial begin
    test_reset();
    test_paths();
    test_fetch_stall();
    test_illegal();
    test_watchdog();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit opcode held in IR.
- Sequences fetch, decode, execute, memory and writeback steps.
- Drives every datapath enable and mux select, including the 2-bit ALUOp consumed by the ALU control decoder (00 add, 01 sub, 10 use funct).
- Memory steps stall on a ready handshake, with a watchdog timeout.

Parameters:
- TIMEOUT, 255, max consecutive stall cycles in a memory state before abort; 0 disables the watchdog.
- CNT_W, 8, width of the stall counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- Opcode  in  6  IR[31:26]
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- IorD  out  1  0=PC address, 1=ALUOut address
- MemRead  out  1  memory read
- MemWrite  out  1  memory write
- MemtoReg  out  1  0=ALUOut, 1=MDR to register file
- IRWrite  out  1  IR load
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- ALUOp  out  2  to ALU control
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- RegWrite  out  1  register file write
- RegDst  out  1  0=rt, 1=rd
- state  out  4  current state code (debug)
- illegal_op  out  1  one-cycle pulse on unknown opcode
- mem_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- Reset:
  - rst_n low at a rising edge sets state=FETCH, stall counter=0, pulse registers=0.
  - While rst_n is low, all control outputs, illegal_op and mem_timeout are forced to 0 combinationally.
  - The state output shows the register value, which reads 0 after the first reset edge.
  - Reset mid-instruction abandons it; no write occurs after reset is sampled.
- Outputs are a Moore decode of state; every signal not listed below is 0.
  - FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready (qualified combinationally).
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR and ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
- Transitions:
  - FETCH, MEMRD, MEMWR: hold while mem_ready=0; advance when mem_ready=1.
    - FETCH goes to DECODE, MEMRD to MEMWB, MEMWR to FETCH.
  - DECODE on Opcode:
    - 000000 goes to EXEC.
    - 100011 (lw) and 101011 (sw) go to MEMADR.
    - 000100 goes to BRANCH.
    - 000010 goes to JUMP.
    - 001000 goes to ADDI_EX.
    - Any other opcode goes to FETCH and pulses illegal_op one cycle (registered, high in the following cycle).
  - MEMADR: lw goes to MEMRD, sw goes to MEMWR; Opcode is re-sampled here and is stable because IR is not written.
  - EXEC goes to RWB; ADDI_EX goes to ADDI_WB.
  - MEMWB, RWB, BRANCH, JUMP, ADDI_WB go to FETCH.
- Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
- Watchdog:
  - The counter clears on every state change and whenever mem_ready=1.
  - It increments each cycle spent in a wait state with mem_ready=0.
  - When the counter equals TIMEOUT-1 and mem_ready is still 0, the next state is FETCH and mem_timeout pulses in the following cycle.
  - No IRWrite or PCWrite is issued on an aborted fetch.
  - The counter saturates and never wraps.
  - TIMEOUT=0 means stall indefinitely.
- mem_ready arriving in the same cycle as the timeout: the ready wins, normal advance, no pulse.

Test Plan:
- Reset, R-type: rst_n=0 for 2 cycles -> all outputs 0; release with Opcode=000000, mem_ready=1 -> states 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=1 and RegDst=1 in RWB.
- lw with stall: Opcode=100011, mem_ready low 3 cycles in FETCH then 1 -> FETCH held 4 cycles, IRWrite high only on the last; then states 1,2,3,4,0; MemtoReg=1 at state 4.
- sw, beq, j, addi: each yields its path; BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01; JUMP shows PCSource=10, PCWrite=1; total cycles 4/3/3/4.
- Illegal opcode: Opcode=111111 -> DECODE then FETCH; illegal_op high exactly 1 cycle; no RegWrite or MemWrite.
- Watchdog with TIMEOUT=4: MEMRD with mem_ready=0 -> 4 cycles in state 3, then state 0, mem_timeout=1 for 1 cycle; repeat with mem_ready=1 on the 4th stall cycle -> MEMWB, no pulse.
- Mid-op reset: assert rst_n=0 during MEMWR -> MemWrite drops to 0 immediately; next edge gives state=0.
